// File: rtl/booth_alu_param.sv
// booth_alu_param: iterative multiply / divide / modulo unit for the calculator
// datapath. MUL uses Booth recoding and DIV/MOD use restoring division on the
// operand magnitudes. Both signed and unsigned operands are supported.
// Build option: define BOOTH_RADIX4_EN to use radix-4 Booth recoding for MUL.
// This takes WIDTH/2 iterations instead of WIDTH and gives identical results.
// Handshake: a rising edge of parser_done seen in IDLE starts one operation and
// latches the operands. busy is high from the start until the cycle in which
// alu_done pulses for one cycle, and calc_res is updated on that same edge.
// A start seen while busy is dropped; it is not queued.
module booth_alu_param #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [3:0]         dtype,
  input  logic [4:0]         operator,
  input  logic [WIDTH-1:0]   src1,
  input  logic [WIDTH-1:0]   src2,
  input  logic               parser_done,
  output logic [2*WIDTH:0]   calc_res,
  output logic               alu_done,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  localparam logic [4:0] OP_MUL = 5'h03;
  localparam logic [4:0] OP_DIV = 5'h04;
  localparam logic [4:0] OP_MOD = 5'h05;

  // The product accumulator has two spare bits. One covers the zero-extended
  // unsigned multiplicand, and one keeps the Booth sum from overflowing.
  localparam int PW = 2 * WIDTH + 2;
  localparam int CW = $clog2(WIDTH);
`ifdef BOOTH_RADIX4_EN
  localparam int MUL_STEP = 2;
`else
  localparam int MUL_STEP = 1;
`endif
  localparam int MUL_ITERS = WIDTH / MUL_STEP;
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_ITERS - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

  state_t state, state_d;

  logic                pd_q;
  logic                start;
  logic                start_err;
  logic                op_is_div;
  logic                op_known;
  logic                is_mul;
  logic                is_mod;
  logic                op_signed;
  logic                a_neg;
  logic                b_neg;
  logic                q_msb;
  logic                err;
  logic [CW-1:0]       cnt;

  logic signed [PW-1:0] acc;
  logic signed [PW-1:0] mcand;
  logic signed [PW-1:0] booth_add;
  logic signed [PW-1:0] mul_sum;
  logic [WIDTH-1:0]     q;
  logic                 q_prev;

  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     dvs;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic                 div_fit;

  logic [2*WIDTH-1:0]   quo_ext;
  logic [2*WIDTH-1:0]   rem_ext;
  logic [2*WIDTH-1:0]   div_res;
  logic [2*WIDTH-1:0]   mod_res;
  logic [2*WIDTH-1:0]   result;
  logic                 unused_bits;

  assign op_is_div = (operator == OP_DIV) || (operator == OP_MOD);
  assign op_known  = (operator == OP_MUL) || op_is_div;
  assign start_err = ~op_known | (op_is_div & (src2 == '0));
  assign start     = parser_done & ~pd_q & (state == S_IDLE);
  assign a_mag     = (dtype[0] & src1[WIDTH-1]) ? -src1 : src1;
  assign b_mag     = (dtype[0] & src2[WIDTH-1]) ? -src2 : src2;
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  // Booth digit selection from the low multiplier bits and the bit shifted out last.
  always_comb begin
    booth_add = '0;
`ifdef BOOTH_RADIX4_EN
    case ({q[1], q[0], q_prev})
      3'b001, 3'b010: booth_add = mcand;
      3'b011:         booth_add = mcand <<< 1;
      3'b100:         booth_add = -(mcand <<< 1);
      3'b101, 3'b110: booth_add = -mcand;
      default:        booth_add = '0;
    endcase
`else
    case ({q[0], q_prev})
      2'b01:   booth_add = mcand;
      2'b10:   booth_add = -mcand;
      default: booth_add = '0;
    endcase
`endif
  end

  // Booth treats the multiplier as signed. An unsigned multiplier with its top
  // bit set is therefore short by M*2^W. After all the shifts, mcand holds
  // exactly that amount, so the missing top digit is added back here.
  assign mul_sum = acc + ((~op_signed & q_msb) ? mcand : '0);

  // One restoring step: shift in the next dividend bit, then subtract if it fits.
  assign div_shift = {rem, quo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, dvs};
  assign div_fit   = (div_shift >= {1'b0, dvs});

  // Sign correction. A minimum / -1 quotient stays positive, because the
  // magnitude is zero-extended before it is conditionally negated.
  assign quo_ext = {{WIDTH{1'b0}}, quo};
  assign rem_ext = {{WIDTH{1'b0}}, rem};
  assign div_res = (op_signed & (a_neg ^ b_neg)) ? -quo_ext : quo_ext;
  assign mod_res = (op_signed & a_neg) ? -rem_ext : rem_ext;
  assign result  = is_mul ? mul_sum[2*WIDTH-1:0] : (is_mod ? mod_res : div_res);

  assign unused_bits = ^{dtype[3:1], mul_sum[PW-1:2*WIDTH], div_diff[WIDTH]};

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!n_rst) state <= S_IDLE;
    else        state <= state_d;
  end

  // Next-state logic: the iteration counter decides when MUL/DIV go to FIN.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (start_err)                state_d = S_FIN;
          else if (operator == OP_MUL)  state_d = S_MUL;
          else                          state_d = S_DIV;
        end
      end
      S_MUL, S_DIV: if (cnt == '0) state_d = S_FIN;
      S_FIN:        state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Datapath: latch on start, iterate in MUL/DIV, publish the result in FIN.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      pd_q      <= 1'b0;
      alu_done  <= 1'b0;
      calc_res  <= '0;
      is_mul    <= 1'b0;
      is_mod    <= 1'b0;
      op_signed <= 1'b0;
      a_neg     <= 1'b0;
      b_neg     <= 1'b0;
      q_msb     <= 1'b0;
      err       <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      q         <= '0;
      q_prev    <= 1'b0;
      rem       <= '0;
      quo       <= '0;
      dvs       <= '0;
    end else begin
      pd_q     <= parser_done;
      alu_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            is_mul    <= (operator == OP_MUL);
            is_mod    <= (operator == OP_MOD);
            op_signed <= dtype[0];
            err       <= start_err;
            a_neg     <= dtype[0] & src1[WIDTH-1];
            b_neg     <= dtype[0] & src2[WIDTH-1];
            q_msb     <= src2[WIDTH-1];
            acc       <= '0;
            mcand     <= {{(PW-WIDTH){dtype[0] & src1[WIDTH-1]}}, src1};
            q         <= src2;
            q_prev    <= 1'b0;
            quo       <= a_mag;
            rem       <= '0;
            dvs       <= b_mag;
            cnt       <= (operator == OP_MUL) ? MUL_LAST : DIV_LAST;
          end
        end
        S_MUL: begin
          acc    <= acc + booth_add;
          mcand  <= mcand <<< MUL_STEP;
          q_prev <= q[MUL_STEP-1];
          q      <= q >> MUL_STEP;
          cnt    <= cnt - 1'b1;
        end
        S_DIV: begin
          rem <= div_fit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], div_fit};
          cnt <= cnt - 1'b1;
        end
        S_FIN: begin
          alu_done <= 1'b1;
          calc_res <= err ? {1'b1, {(2*WIDTH){1'b0}}} : {1'b0, result};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_alu_param.sv
// Bench for booth_alu_param at WIDTH = 16. Directed cases from the operation
// rules are followed by randomized operations. Each random case is checked
// against an arithmetic reference model that uses 64-bit integer multiply,
// divide and remainder.
module tb_booth_alu_param;

  localparam int W = 16;
`ifdef BOOTH_RADIX4_EN
  localparam int MUL_LAT = W / 2 + 1;
`else
  localparam int MUL_LAT = W + 1;
`endif
  localparam int RUN_CYCLES = W + 4;

  logic           clk = 1'b0;
  logic           n_rst;
  logic [3:0]     dtype;
  logic [4:0]     operator;
  logic [W-1:0]   src1;
  logic [W-1:0]   src2;
  logic           parser_done;
  logic [2*W:0]   calc_res;
  logic           alu_done;
  logic           busy;
  logic [1:0]     dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  booth_alu_param #(.WIDTH(W)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .dtype       (dtype),
    .operator    (operator),
    .src1        (src1),
    .src2        (src2),
    .parser_done (parser_done),
    .calc_res    (calc_res),
    .alu_done    (alu_done),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on sign- or zero-extended operands.
  function automatic logic [2*W:0] model(input logic sgn, input logic [4:0] op,
                                         input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, r;
    logic [2*W:0] res;
    sa  = sgn ? longint'($signed(a)) : longint'(a);
    sb  = sgn ? longint'($signed(b)) : longint'(b);
    res = {1'b1, {(2*W){1'b0}}};
    if (op == 5'h03) begin
      r   = sa * sb;
      res = {1'b0, r[2*W-1:0]};
    end else if ((op == 5'h04 || op == 5'h05) && sb != 0) begin
      r   = (op == 5'h04) ? sa / sb : sa % sb;
      res = {1'b0, r[2*W-1:0]};
    end
    return res;
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 16'h8000;
      3:       return 16'h0001;
      default: return W'($urandom);
    endcase
  endfunction

  // driver: one operation, checked cycle by cycle against the expected latency
  task automatic run_op(input string tag, input logic [3:0] dt, input logic [4:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W:0] exp, input int hold, input int restart_at);
    int lat;
    lat = exp[2*W] ? 1 : ((op == 5'h03) ? MUL_LAT : W + 1);
    dtype = dt; operator = op; src1 = a; src2 = b; parser_done = 1'b1;
    @(posedge clk); #1;
    if (hold <= 1) parser_done = 1'b0;
    check({tag, ":busy_at_start"}, busy, 1);
    for (int c = 1; c <= RUN_CYCLES; c++) begin
      dtype = 4'($urandom); operator = 5'($urandom);
      src1 = W'($urandom);  src2 = W'($urandom);
      @(posedge clk); #1;
      check({tag, ":alu_done"}, alu_done, (c == lat));
      check({tag, ":busy"}, busy, (c < lat));
      if (c == lat) check({tag, ":calc_res"}, calc_res, exp);
      if (restart_at > 0 && c >= restart_at - 1) parser_done = 1'b1;
      else if (c >= hold - 1) parser_done = 1'b0;
    end
    parser_done = 1'b0;
    @(posedge clk); #1;
    check({tag, ":calc_res_hold"}, calc_res, exp);
    check({tag, ":no_late_done"}, alu_done, 0);
  endtask

  initial begin
    logic [3:0]   r_dt;
    logic [4:0]   r_op;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;

    n_rst = 1'b0; parser_done = 1'b0; dtype = '0; operator = '0; src1 = '0; src2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_calc_res", calc_res, 0);
    check("reset_alu_done", alu_done, 0);
    check("reset_busy", busy, 0);
    check("reset_state_idle", dbg_state, 0);

    // The first edge after reset release already sees parser_done high.
    n_rst = 1'b1;
    run_op("mul_u_8x2_hold3", 4'h0, 5'h03, 16'h0008, 16'h0002, 33'h0_0000_0010, 3, 0);
    run_op("mul_s_neg3x5",    4'h1, 5'h03, 16'hFFFD, 16'h0005, 33'h0_FFFF_FFF1, 1, 0);
    run_op("mul_s_min_sq",    4'h1, 5'h03, 16'h8000, 16'h8000, 33'h0_4000_0000, 2, 0);
    run_op("mul_u_max_sq",    4'h0, 5'h03, 16'hFFFF, 16'hFFFF, 33'h0_FFFE_0001, 1, 0);
    run_op("mul_u_dtype_hi",  4'hE, 5'h03, 16'hFFFF, 16'h0002, 33'h0_0001_FFFE, 1, 0);
    run_op("div_s_neg7_2",    4'h1, 5'h04, 16'hFFF9, 16'h0002, 33'h0_FFFF_FFFD, 1, 0);
    run_op("mod_s_neg7_2",    4'h1, 5'h05, 16'hFFF9, 16'h0002, 33'h0_FFFF_FFFF, 1, 0);
    run_op("div_u_fff9_2",    4'h0, 5'h04, 16'hFFF9, 16'h0002, 33'h0_0000_7FFC, 1, 0);
    run_op("div_s_min_neg1",  4'h1, 5'h04, 16'h8000, 16'hFFFF, 33'h0_0000_8000, 1, 0);
    run_op("div_by_zero",     4'h1, 5'h04, 16'h1234, 16'h0000, 33'h1_0000_0000, 1, 0);
    run_op("mod_by_zero",     4'h0, 5'h05, 16'h1234, 16'h0000, 33'h1_0000_0000, 1, 0);
    run_op("bad_operator",    4'h0, 5'h1F, 16'h0008, 16'h0002, 33'h1_0000_0000, 1, 0);
    run_op("start_while_busy", 4'h1, 5'h03, 16'h0123, 16'hFF00, 33'h0_FFFE_DD00, 1, 4);

    // Reset during a MUL: drop n_rst for the edge at cycle 5 after the start.
    dtype = 4'h1; operator = 5'h03; src1 = 16'h1234; src2 = 16'h0F0F; parser_done = 1'b1;
    @(posedge clk); #1;
    parser_done = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      check("mid_reset_busy_before", busy, 1);
    end
    n_rst = 1'b0;
    parser_done = 1'b1;
    @(posedge clk); #1;
    n_rst = 1'b1;
    check("mid_reset_alu_done", alu_done, 0);
    check("mid_reset_busy", busy, 0);
    check("mid_reset_calc_res", calc_res, 0);
    run_op("after_reset_mul", 4'h1, 5'h03, 16'h7FFF, 16'h7FFF, 33'h0_3FFF_0001, 1, 0);

    // randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      r_dt = 4'($urandom_range(0, 15));
      r_op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(3, 5));
      r_a  = pick_operand();
      r_b  = pick_operand();
      run_op("random_op", r_dt, r_op, r_a, r_b, model(r_dt[0], r_op, r_a, r_b),
             int'($urandom_range(1, 3)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
